// File: rtl/proc_pkg.sv
// Shared processor definitions: common-data-bus defaults and the result record
// exchanged between functional units, reservation stations and the ROB.
package proc_pkg;

    localparam int CDB_NUM_SRC    = 4;
    localparam int TAG_WIDTH      = 8;
    localparam int DATA_WIDTH     = 128;
    localparam int CDB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_result_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO (power-of-two depth) with wrap-bit pointers; the head
// entry is exposed combinationally so the arbiter can launch it directly.
module cdb_src_fifo
    import proc_pkg::*;
#(
    parameter int tag_width  = TAG_WIDTH,
    parameter int data_width = DATA_WIDTH,
    parameter int fifo_depth = CDB_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [tag_width-1:0]  i_tag,
    input  logic [data_width-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [tag_width-1:0]  o_head_tag,
    output logic [data_width-1:0] o_head_data
);

    localparam int AW = $clog2(fifo_depth);

    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic [tag_width-1:0]  r_tag_mem  [fifo_depth];
    logic [data_width-1:0] r_data_mem [fifo_depth];
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage is not reset: emptiness is defined solely by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_tag_mem[r_wptr[AW-1:0]]  <= i_tag;
            r_data_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    assign o_head_tag  = r_tag_mem[r_rptr[AW-1:0]];
    assign o_head_data = r_data_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/cdb_broadcaster.sv
// Common-data-bus producer: per-source FIFOs, round-robin arbiter, registered bus.
// Optional macro CDB_STATS_EN adds saturating broadcast and stall counters.
module cdb_broadcaster
    import proc_pkg::*;
#(
    parameter int num_src    = CDB_NUM_SRC,
    parameter int tag_width  = TAG_WIDTH,
    parameter int data_width = DATA_WIDTH,
    parameter int fifo_depth = CDB_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [num_src-1:0]           src_valid_IN,
    input  logic [num_src*tag_width-1:0] src_tag_IN,
    input  logic [num_src*data_width-1:0] src_data_IN,
    output logic [num_src-1:0]           src_ready_OUT,
    input  logic                         hold_IN,
    output logic                         bcast_OUT,
    output logic [tag_width-1:0]         bcast_tag_OUT,
    output logic [data_width-1:0]        bcast_data_OUT,
`ifdef CDB_STATS_EN
    output logic [31:0]                  bcast_count_OUT,
    output logic [31:0]                  stall_count_OUT,
`endif
    output logic [$clog2(num_src)-1:0]   bcast_src_OUT
);

    localparam int SW = $clog2(num_src);

    logic [num_src-1:0]    w_full;
    logic [num_src-1:0]    w_empty;
    logic [num_src-1:0]    w_pop_vec;
    logic [tag_width-1:0]  w_head_tag  [num_src];
    logic [data_width-1:0] w_head_data [num_src];
    logic                  w_win_any;
    logic [SW-1:0]         w_win_idx;
    logic [SW:0]           w_sum;
    logic                  w_pop;

    logic [SW-1:0]         r_rr_ptr;
    logic                  r_bcast_vld_p1;
    logic [tag_width-1:0]  r_bcast_tag_p1;
    logic [data_width-1:0] r_bcast_data_p1;
    logic [SW-1:0]         r_bcast_src_p1;

    // Stage 0: per-source buffering
    for (genvar g = 0; g < num_src; g++) begin : g_src
        cdb_src_fifo #(
            .tag_width  (tag_width),
            .data_width (data_width),
            .fifo_depth (fifo_depth)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst),
            .i_push      (src_valid_IN[g] & ~w_full[g]),
            .i_tag       (src_tag_IN[g*tag_width +: tag_width]),
            .i_data      (src_data_IN[g*data_width +: data_width]),
            .i_pop       (w_pop_vec[g]),
            .o_full      (w_full[g]),
            .o_empty     (w_empty[g]),
            .o_head_tag  (w_head_tag[g]),
            .o_head_data (w_head_data[g])
        );
    end

    assign src_ready_OUT = ~w_full;

    always_comb begin
        w_win_any = 1'b0;
        w_win_idx = '0;
        w_sum     = '0;
        for (int k = 0; k < num_src; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (SW+1)'(k);
            if (w_sum >= (SW+1)'(num_src)) w_sum = w_sum - (SW+1)'(num_src);
            if (!w_win_any && !w_empty[w_sum[SW-1:0]]) begin
                w_win_any = 1'b1;
                w_win_idx = w_sum[SW-1:0];
            end
        end
    end

    assign w_pop = w_win_any & ~hold_IN;

    always_comb begin
        w_pop_vec = '0;
        for (int i = 0; i < num_src; i++) begin
            w_pop_vec[i] = w_pop && (w_win_idx == SW'(i));
        end
    end

    // Stage 1: registered bus; tag/data/src hold their last values when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr        <= '0;
            r_bcast_vld_p1  <= 1'b0;
            r_bcast_tag_p1  <= '0;
            r_bcast_data_p1 <= '0;
            r_bcast_src_p1  <= '0;
        end else begin
            r_bcast_vld_p1 <= w_pop;
            if (w_pop) begin
                r_rr_ptr        <= (w_win_idx == SW'(num_src - 1)) ? '0 : w_win_idx + SW'(1);
                r_bcast_tag_p1  <= w_head_tag[w_win_idx];
                r_bcast_data_p1 <= w_head_data[w_win_idx];
                r_bcast_src_p1  <= w_win_idx;
            end
        end
    end

    assign bcast_OUT      = r_bcast_vld_p1;
    assign bcast_tag_OUT  = r_bcast_tag_p1;
    assign bcast_data_OUT = r_bcast_data_p1;
    assign bcast_src_OUT  = r_bcast_src_p1;

`ifdef CDB_STATS_EN
    logic [31:0] r_bcast_cnt;
    logic [31:0] r_stall_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A stall is a cycle where some source offers a result into a full FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcast_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop)                          r_bcast_cnt <= sat_inc(r_bcast_cnt);
            if (|(w_full & src_valid_IN))       r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign bcast_count_OUT = r_bcast_cnt;
    assign stall_count_OUT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: vector table, directed sequences and
// random traffic against a queue-based reference model.
module tb_cdb_broadcaster;
    import proc_pkg::*;

    localparam int NS = 4;
    localparam int TW = 8;
    localparam int DW = 128;
    localparam int FD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     valid;
    logic [NS*TW-1:0]  tag_in;
    logic [NS*DW-1:0]  data_in;
    logic              hold;
    logic [NS-1:0]     src_ready;
    logic              bcast;
    logic [TW-1:0]     btag;
    logic [DW-1:0]     bdata;
    logic [1:0]        bsrc;
`ifdef CDB_STATS_EN
    logic [31:0]       bc_o;
    logic [31:0]       sc_o;
    int                m_bc;
    int                m_stall;
`endif

    always #5 clk = ~clk;

    cdb_broadcaster dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid_IN   (valid),
        .src_tag_IN     (tag_in),
        .src_data_IN    (data_in),
        .src_ready_OUT  (src_ready),
        .hold_IN        (hold),
        .bcast_OUT      (bcast),
        .bcast_tag_OUT  (btag),
        .bcast_data_OUT (bdata),
`ifdef CDB_STATS_EN
        .bcast_count_OUT(bc_o),
        .stall_count_OUT(sc_o),
`endif
        .bcast_src_OUT  (bsrc)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: one queue per source, a round-robin pointer, and the last bus value.
    cdb_result_t   mq [NS][$];
    int            m_ptr;
    logic          m_bcast;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    int            m_src;
    logic [TW-1:0] blog [$];

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    task automatic set_src(int i, logic [TW-1:0] t, logic [DW-1:0] d);
        tag_in[i*TW +: TW]  = t;
        data_in[i*DW +: DW] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NS; i++) mq[i].delete();
        m_ptr = 0; m_bcast = 1'b0; m_tag = '0; m_data = '0; m_src = 0;
        blog.delete();
`ifdef CDB_STATS_EN
        m_bc = 0; m_stall = 0;
`endif
    endtask

    // One clock: check ready before the edge, advance the model, check the bus after it.
    task automatic tick();
        logic [NS-1:0] rdy;
        int win;
        cdb_result_t e;
        for (int i = 0; i < NS; i++) rdy[i] = (mq[i].size() < FD);
        chk("ready", 128'(src_ready), 128'(rdy));
        win = -1;
        if (!hold) begin
            for (int k = 0; k < NS; k++) begin
                int idx;
                idx = (m_ptr + k) % NS;
                if (win < 0 && mq[idx].size() > 0) win = idx;
            end
        end
`ifdef CDB_STATS_EN
        if (|(valid & ~rdy)) m_stall++;
`endif
        @(posedge clk);
        if (win >= 0) begin
            e = mq[win].pop_front();
            m_bcast = 1'b1; m_tag = e.tag; m_data = e.data; m_src = win;
            m_ptr = (win + 1) % NS;
`ifdef CDB_STATS_EN
            m_bc++;
`endif
        end else begin
            m_bcast = 1'b0;
        end
        for (int i = 0; i < NS; i++) begin
            if (valid[i] && rdy[i]) begin
                e.valid = 1'b1; e.tag = tag_in[i*TW +: TW]; e.data = data_in[i*DW +: DW];
                mq[i].push_back(e);
            end
        end
        #1;
        chk("bcast", 128'(bcast), 128'(m_bcast));
        chk("btag", 128'(btag), 128'(m_tag));
        chk("bdata", bdata, m_data);
        chk("bsrc", 128'(bsrc), 128'(m_src));
`ifdef CDB_STATS_EN
        chk("bcast_count", 128'(bc_o), 128'(m_bc));
        chk("stall_count", 128'(sc_o), 128'(m_stall));
`endif
        if (bcast) blog.push_back(btag);
    endtask

    // Asynchronous reset asserted mid-cycle, held across one rising edge.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_bcast", 128'(bcast), 128'd0);
        chk("rst_ready", 128'(src_ready), 128'hF);
        chk("rst_tag", 128'(btag), 128'd0);
        chk("rst_data", bdata, 128'd0);
        chk("rst_src", 128'(bsrc), 128'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid = '0;
        hold = 1'b0;
    endtask

    typedef struct {
        logic [NS-1:0] v;
        logic [TW-1:0] base;
        logic          h;
        logic          eb;
        logic [TW-1:0] etag;
        logic [1:0]    esrc;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int sent;
        int cyc;
        logic [TW-1:0] t;

        rst = 1'b0; valid = '0; hold = 1'b0; tag_in = '0; data_in = '0;
        model_clear();
        @(posedge clk); #1;
        do_reset();

        // Vector table from a freshly reset state (round-robin pointer 0).
        tbl[0]  = '{4'b0100, 8'h28, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 8'h2A, 2'd2};
        tbl[2]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[3]  = '{4'b1111, 8'h40, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[4]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 8'h43, 2'd3};
        tbl[5]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 8'h40, 2'd0};
        tbl[6]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 8'h41, 2'd1};
        tbl[7]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 8'h42, 2'd2};
        tbl[8]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[9]  = '{4'b0011, 8'h50, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[10] = '{4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[11] = '{4'b0000, 8'h00, 1'b0, 1'b1, 8'h50, 2'd0};
        tbl[12] = '{4'b0000, 8'h00, 1'b0, 1'b1, 8'h51, 2'd1};
        tbl[13] = '{4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0};
        for (int r = 0; r < 14; r++) begin
            valid = tbl[r].v;
            hold  = tbl[r].h;
            for (int i = 0; i < NS; i++) begin
                t = tbl[r].base + 8'(i);
                set_src(i, t, {16{t}});
            end
            chk("tbl_ready", 128'(src_ready), 128'hF);
            tick();
            chk("tbl_bcast", 128'(bcast), 128'(tbl[r].eb));
            if (tbl[r].eb) begin
                chk("tbl_tag", 128'(btag), 128'(tbl[r].etag));
                chk("tbl_data", bdata, {16{tbl[r].etag}});
                chk("tbl_src", 128'(bsrc), 128'(tbl[r].esrc));
            end
        end
        valid = '0; hold = 1'b0;

        // Reset mid-burst discards buffered results.
        do_reset();
        hold = 1'b1; valid = 4'b0001;
        set_src(0, 8'h10, 128'h10); tick();
        set_src(0, 8'h11, 128'h11); tick();
        valid = '0;
        do_reset();
        for (int c = 0; c < 5; c++) tick();
        chk("rst_discard", 128'(blog.size()), 128'd0);

        // Single result latency.
        valid = 4'b0100; set_src(2, 8'h2A, 128'hDEAD);
        tick();
        chk("single_n", 128'(bcast), 128'd0);
        valid = '0;
        tick();
        chk("single_b", 128'(bcast), 128'd1);
        chk("single_tag", 128'(btag), 128'h2A);
        chk("single_data", bdata, 128'hDEAD);
        chk("single_src", 128'(bsrc), 128'd2);
        tick();
        chk("single_n2", 128'(bcast), 128'd0);

        // Round-robin fairness across four full FIFOs.
        do_reset();
        hold = 1'b1; valid = 4'b1111;
        for (int i = 0; i < NS; i++) set_src(i, 8'h60 + 8'(i), 128'(i));
        tick();
        for (int i = 0; i < NS; i++) set_src(i, 8'h70 + 8'(i), 128'(i + 16));
        tick();
        valid = '0; hold = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rr_valid", 128'(bcast), 128'd1);
            chk("rr_src", 128'(bsrc), 128'(c % NS));
        end

        // Backpressure: hold while src1 offers three results.
        do_reset();
        hold = 1'b1; sent = 0;
        for (int c = 0; c < 5; c++) begin
            valid = (sent < 3) ? 4'b0010 : 4'b0000;
            set_src(1, 8'h80 + 8'(sent), 128'(sent));
            if (src_ready[1] && sent < 3) begin
                tick(); sent++;
            end else begin
                tick();
            end
        end
        chk("bp_ready1", 128'(src_ready[1]), 128'd0);
        chk("bp_accepted", 128'(sent), 128'd2);
        chk("bp_no_bcast", 128'(blog.size()), 128'd0);
        hold = 1'b0; cyc = 0;
        while (blog.size() < 3 && cyc < 12) begin
            valid = (sent < 3) ? 4'b0010 : 4'b0000;
            set_src(1, 8'h80 + 8'(sent), 128'(sent));
            if (src_ready[1] && sent < 3) begin
                tick(); sent++;
            end else begin
                tick();
            end
            cyc++;
        end
        chk("bp_count", 128'(blog.size()), 128'd3);
        for (int k = 0; k < 3 && k < blog.size(); k++) chk("bp_order", 128'(blog[k]), 128'(8'h80 + 8'(k)));

        // Streaming through src3 wraps the pointers with simultaneous push and pop.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            valid = 4'b1000;
            set_src(3, 8'hA0 + 8'(k), {4{32'(k)}});
            chk("stream_ready", 128'(src_ready[3]), 128'd1);
            tick();
        end
        valid = '0;
        tick(); tick();
        chk("stream_count", 128'(blog.size()), 128'd16);
        for (int k = 0; k < 16 && k < blog.size(); k++) chk("stream_order", 128'(blog[k]), 128'(8'hA0 + 8'(k)));

`ifdef CDB_STATS_EN
        do_reset();
        valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            set_src(0, 8'(k), 128'(k));
            tick();
        end
        valid = '0;
        tick(); tick();
        chk("stats_bcast10", 128'(bc_o), 128'd10);
        do_reset();
        hold = 1'b1; valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            set_src(0, 8'(k), 128'(k));
            tick();
        end
        chk("stats_stall3", 128'(sc_o), 128'd3);
        valid = '0; hold = 1'b0;
`endif

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            valid = NS'($urandom);
            hold  = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NS; i++) set_src(i, 8'($urandom), {$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        valid = '0; hold = 1'b0;
        for (int c = 0; c < 10; c++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
